// File: rtl/key_updown_counter_pkg.sv
// Shared types and defaults for the push-button up/down counter.
//   rpt_state_t          : per-key auto-repeat state
//   DEF_*_CYC            : default cycle counts for a 50 MHz clock
//   cnt_width()          : counter width able to hold 0..n-1
package key_updown_counter_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } rpt_state_t;

  localparam int unsigned DEF_DEBOUNCE_CYC     = 500_000;     // 10 ms
  localparam int unsigned DEF_REPEAT_DELAY_CYC = 25_000_000;  // 0.5 s
  localparam int unsigned DEF_REPEAT_RATE_CYC  = 5_000_000;   // 0.1 s

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dec7seg.sv
// Hex nibble to seven-segment pattern, active-low segments {g,f,e,d,c,b,a}.
//   nibble_i : value 0..F
//   seg_o    : segment drive, 0 = lit
module dec7seg (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  logic [6:0] lit;

  always_comb begin
    lit = '0;
    case (nibble_i)
      4'h0: lit = 7'h3F;
      4'h1: lit = 7'h06;
      4'h2: lit = 7'h5B;
      4'h3: lit = 7'h4F;
      4'h4: lit = 7'h66;
      4'h5: lit = 7'h6D;
      4'h6: lit = 7'h7D;
      4'h7: lit = 7'h07;
      4'h8: lit = 7'h7F;
      4'h9: lit = 7'h6F;
      4'hA: lit = 7'h77;
      4'hB: lit = 7'h7C;
      4'hC: lit = 7'h39;
      4'hD: lit = 7'h5E;
      4'hE: lit = 7'h79;
      default: lit = 7'h71;
    endcase
  end

  assign seg_o = ~lit;

endmodule

// File: rtl/key_updown_counter_key_conditioner.sv
// Raw push-button conditioning: 2-FF synchroniser, debounce, press/repeat
// step generation. Emits a registered one-cycle step pulse.
// Optional feature macro: KEY_UPDOWN_COUNTER_AUTOREPEAT_EN (held key repeats).
//   clock_50 : clock
//   reset_n  : synchronous active-low reset
//   key_n_i  : raw button, active-low, asynchronous
//   step_o   : one-cycle step pulse
module key_conditioner
  import key_updown_counter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC,
  parameter int unsigned REPEAT_DELAY_CYC = DEF_REPEAT_DELAY_CYC,
  parameter int unsigned REPEAT_RATE_CYC  = DEF_REPEAT_RATE_CYC
) (
  input  logic clock_50,
  input  logic reset_n,
  input  logic key_n_i,
  output logic step_o
);

  if (DEBOUNCE_CYC < 1 || REPEAT_DELAY_CYC < 1 || REPEAT_RATE_CYC < 1) begin : g_bad_cyc
    $error("key_conditioner: cycle counts must be at least 1");
  end

  localparam int unsigned DB_W = cnt_width(DEBOUNCE_CYC);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  // Synchroniser idles high (released).
  logic [1:0] sync_q;
  logic       pressed_q, pressed_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic       step_q, step_d;
  logic       key_lvl;

  assign key_lvl = ~sync_q[1];

  // Counts consecutive cycles the synchronised level disagrees with the
  // debounced level; any agreeing cycle restarts the count.
  always_comb begin
    pressed_d = pressed_q;
    db_cnt_d  = '0;
    if (key_lvl != pressed_q) begin
      if (db_cnt_q == DB_LAST) begin
        pressed_d = key_lvl;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clock_50) begin
    if (!reset_n) begin
      sync_q    <= '1;
      pressed_q <= 1'b0;
      db_cnt_q  <= '0;
      step_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], key_n_i};
      pressed_q <= pressed_d;
      db_cnt_q  <= db_cnt_d;
      step_q    <= step_d;
    end
  end

`ifdef KEY_UPDOWN_COUNTER_AUTOREPEAT_EN
  localparam int unsigned TMR_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ?
                                    REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
  localparam int unsigned TMR_W   = cnt_width(TMR_MAX);
  localparam logic [TMR_W-1:0] TMR_DELAY = TMR_W'(REPEAT_DELAY_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_RATE  = TMR_W'(REPEAT_RATE_CYC - 1);

  rpt_state_t       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;

  // Release is tested before timer expiry so it wins in the same cycle.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    step_d  = 1'b0;
    case (state_q)
      RPT_IDLE: begin
        if (pressed_q) begin
          step_d  = 1'b1;
          tmr_d   = TMR_DELAY;
          state_d = RPT_DELAY;
        end
      end
      RPT_DELAY, RPT_REPEAT: begin
        if (!pressed_q) begin
          tmr_d   = '0;
          state_d = RPT_IDLE;
        end else if (tmr_q == '0) begin
          step_d  = 1'b1;
          tmr_d   = TMR_RATE;
          state_d = RPT_REPEAT;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: begin
        tmr_d   = '0;
        state_d = RPT_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_50) begin
    if (!reset_n) begin
      state_q <= RPT_IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end
`else
  // Single step per debounced press: only the idle-to-pressed transition
  // survives, so a one-bit "already stepped" flag stands in for the FSM.
  logic held_q;

  always_comb begin
    step_d = pressed_q & ~held_q;
  end

  always_ff @(posedge clock_50) begin
    if (!reset_n) begin
      held_q <= 1'b0;
    end else begin
      held_q <= pressed_q;
    end
  end
`endif

  assign step_o = step_q;

endmodule

// File: rtl/key_updown_counter.sv
// Up/down counter driven by two raw push-buttons, with wrap or saturate at
// the bounds and seven-segment display of every nibble.
// Optional feature macro: KEY_UPDOWN_COUNTER_AUTOREPEAT_EN (held key repeats).
//   clock_50  : 50 MHz clock
//   reset_n   : synchronous active-low reset
//   key_inc_n : raw increment button, active-low
//   key_dec_n : raw decrement button, active-low
//   clear     : synchronous clear of count
//   count     : counter value
//   boundary  : one-cycle pulse when a step wraps or is clamped
//   hex       : hex[i] is the segment pattern of count[4i+3:4i]
module key_updown_counter
  import key_updown_counter_pkg::*;
#(
  parameter int unsigned WIDTH            = 8,
  parameter int unsigned DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC,
  parameter int unsigned REPEAT_DELAY_CYC = DEF_REPEAT_DELAY_CYC,
  parameter int unsigned REPEAT_RATE_CYC  = DEF_REPEAT_RATE_CYC,
  parameter bit          SATURATE         = 1'b0
) (
  input  logic                       clock_50,
  input  logic                       reset_n,
  input  logic                       key_inc_n,
  input  logic                       key_dec_n,
  input  logic                       clear,
  output logic [WIDTH-1:0]           count,
  output logic                       boundary,
  output logic [WIDTH/4-1:0][6:0]    hex
);

  if (WIDTH < 4 || WIDTH > 24 || (WIDTH % 4) != 0) begin : g_bad_width
    $error("key_updown_counter: WIDTH must be a multiple of 4 in 4..24");
  end

  logic inc_step, dec_step;

  key_conditioner #(
    .DEBOUNCE_CYC     (DEBOUNCE_CYC),
    .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
    .REPEAT_RATE_CYC  (REPEAT_RATE_CYC)
  ) u_inc (
    .clock_50 (clock_50),
    .reset_n  (reset_n),
    .key_n_i  (key_inc_n),
    .step_o   (inc_step)
  );

  key_conditioner #(
    .DEBOUNCE_CYC     (DEBOUNCE_CYC),
    .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
    .REPEAT_RATE_CYC  (REPEAT_RATE_CYC)
  ) u_dec (
    .clock_50 (clock_50),
    .reset_n  (reset_n),
    .key_n_i  (key_dec_n),
    .step_o   (dec_step)
  );

  logic [WIDTH-1:0] count_q, count_d;
  logic             bnd_q, bnd_d;

  // Boundary is registered alongside count, so in both modes it is high in
  // the cycle after the offending step.
  always_comb begin
    count_d = count_q;
    bnd_d   = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (inc_step && dec_step) begin
      count_d = count_q;
    end else if (inc_step) begin
      if (count_q == '1) begin
        bnd_d = 1'b1;
        if (!SATURATE) count_d = '0;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end else if (dec_step) begin
      if (count_q == '0) begin
        bnd_d = 1'b1;
        if (!SATURATE) count_d = '1;
      end else begin
        count_d = count_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock_50) begin
    if (!reset_n) begin
      count_q <= '0;
      bnd_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      bnd_q   <= bnd_d;
    end
  end

  assign count    = count_q;
  assign boundary = bnd_q;

  for (genvar i = 0; i < WIDTH / 4; i++) begin : g_hex
    dec7seg u_seg (
      .nibble_i (count_q[4*i +: 4]),
      .seg_o    (hex[i])
    );
  end

endmodule

// File: tb/tb_key_updown_counter.sv
module tb_key_updown_counter;

  localparam int D    = 4;
  localparam int DLY  = 20;
  localparam int RATE = 5;
`ifdef KEY_UPDOWN_COUNTER_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic reset_n, key_inc_n, key_dec_n, clear;
  logic [7:0]      cnt_w, cnt_s;
  logic            bnd_w, bnd_s;
  logic [1:0][6:0] hex_w, hex_s;

  key_updown_counter #(.WIDTH(8), .DEBOUNCE_CYC(D), .REPEAT_DELAY_CYC(DLY),
                       .REPEAT_RATE_CYC(RATE), .SATURATE(1'b0)) dut_wrap (
    .clock_50(clk), .reset_n(reset_n), .key_inc_n(key_inc_n), .key_dec_n(key_dec_n),
    .clear(clear), .count(cnt_w), .boundary(bnd_w), .hex(hex_w));

  key_updown_counter #(.WIDTH(8), .DEBOUNCE_CYC(D), .REPEAT_DELAY_CYC(DLY),
                       .REPEAT_RATE_CYC(RATE), .SATURATE(1'b1)) dut_sat (
    .clock_50(clk), .reset_n(reset_n), .key_inc_n(key_inc_n), .key_dec_n(key_dec_n),
    .clear(clear), .count(cnt_s), .boundary(bnd_s), .hex(hex_s));

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int errors = 0;
  int checks = 0;

  // Reference model: index 0 = inc key, 1 = dec key.
  int m_s1 [2];
  int m_s2 [2];
  int m_deb [2];   // 1 = pressed
  int m_run [2];   // consecutive disagreeing samples
  int m_held [2];  // cycles since accepted press, -1 when released
  int m_step [2];
  int m_cw, m_cs, m_bw, m_bs;

  task model_reset();
    for (int k = 0; k < 2; k++) begin
      m_s1[k] = 1; m_s2[k] = 1; m_deb[k] = 0; m_run[k] = 0;
      m_held[k] = -1; m_step[k] = 0;
    end
    m_cw = 0; m_cs = 0; m_bw = 0; m_bs = 0;
  endtask

  task model_edge();
    int up, dn, raw;
    if (!reset_n) begin
      model_reset();
    end else begin
      up = (m_step[0] != 0 && m_step[1] == 0) ? 1 : 0;
      dn = (m_step[1] != 0 && m_step[0] == 0) ? 1 : 0;
      m_bw = 0; m_bs = 0;
      if (clear) begin
        m_cw = 0; m_cs = 0;
      end else if (up != 0) begin
        if (m_cw == 255) m_bw = 1;
        m_cw = (m_cw + 1) % 256;
        if (m_cs == 255) m_bs = 1; else m_cs = m_cs + 1;
      end else if (dn != 0) begin
        if (m_cw == 0) m_bw = 1;
        m_cw = (m_cw + 255) % 256;
        if (m_cs == 0) m_bs = 1; else m_cs = m_cs - 1;
      end
      for (int k = 0; k < 2; k++) begin
        if (m_deb[k] == 0) begin
          m_held[k] = -1;
          m_step[k] = 0;
        end else begin
          m_held[k] = m_held[k] + 1;
          m_step[k] = (m_held[k] == 0 ||
                       (AR && m_held[k] >= DLY && (m_held[k] - DLY) % RATE == 0)) ? 1 : 0;
        end
        if ((m_s2[k] == 0 ? 1 : 0) != m_deb[k]) begin
          m_run[k] = m_run[k] + 1;
          if (m_run[k] == D) begin
            m_deb[k] = (m_s2[k] == 0) ? 1 : 0;
            m_run[k] = 0;
          end
        end else begin
          m_run[k] = 0;
        end
        raw = (k == 0) ? int'(key_inc_n) : int'(key_dec_n);
        m_s2[k] = m_s1[k];
        m_s1[k] = raw;
      end
    end
  endtask

  task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task check_all();
    chk("count_wrap", 32'(cnt_w), 32'(m_cw));
    chk("count_sat", 32'(cnt_s), 32'(m_cs));
    chk("boundary_wrap", 32'(bnd_w), 32'(m_bw));
    chk("boundary_sat", 32'(bnd_s), 32'(m_bs));
    for (int i = 0; i < 2; i++) begin
      chk("hex_wrap", 32'(hex_w[i]), 32'(seg_tab[(m_cw >> (4 * i)) & 15]));
      chk("hex_sat", 32'(hex_s[i]), 32'(seg_tab[(m_cs >> (4 * i)) & 15]));
    end
  endtask

  task tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int nb_w, nb_s, exp_v, p;
    model_reset();
    reset_n = 1'b0; key_inc_n = 1'b1; key_dec_n = 1'b1; clear = 1'b0;

    // 1: reset
    tick(); tick();
    chk("t1_count", 32'(cnt_w), 32'h00);
    chk("t1_boundary", 32'(bnd_w), 32'h0);
    chk("t1_hex0", 32'(hex_w[0]), 32'h40);
    chk("t1_hex1", 32'(hex_w[1]), 32'h40);
    reset_n = 1'b1;
    tick();

    // 2: bouncing inc key, then stable low
    for (int i = 0; i < 6; i++) begin
      key_inc_n = (i % 2 == 1) ? 1'b1 : 1'b0;
      tick(); tick();
    end
    key_inc_n = 1'b0;
    repeat (7) tick();
    chk("t2_before_step", 32'(cnt_w), 32'h00);
    tick();
    chk("t2_step_at_8", 32'(cnt_w), 32'h01);
    repeat (2) tick();
    key_inc_n = 1'b1;
    repeat (10) tick();
    chk("t2_count", 32'(cnt_w), 32'h01);

    // 3: decrement below zero
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t3_clear_wrap", 32'(cnt_w), 32'h00);
    chk("t3_clear_sat", 32'(cnt_s), 32'h00);
    nb_w = 0; nb_s = 0;
    key_dec_n = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (i == 14) key_dec_n = 1'b1;
      tick();
      if (bnd_w) nb_w++;
      if (bnd_s) nb_s++;
    end
    chk("t3_wrap_count", 32'(cnt_w), 32'hFF);
    chk("t3_sat_count", 32'(cnt_s), 32'h00);
    chk("t3_wrap_pulses", 32'(nb_w), 32'd1);
    chk("t3_sat_pulses", 32'(nb_s), 32'd1);

    // 4: long hold of inc
    clear = 1'b1;
    tick();
    clear = 1'b0;
    key_inc_n = 1'b0;
    repeat (58) tick();
    key_inc_n = 1'b1;
    repeat (20) tick();
    exp_v = AR ? 9 : 1;
    chk("t4_hold_wrap", 32'(cnt_w), 32'(exp_v));
    chk("t4_hold_sat", 32'(cnt_s), 32'(exp_v));

    // 5: simultaneous steps, then clear against an inc step
    key_inc_n = 1'b0; key_dec_n = 1'b0;
    repeat (12) tick();
    key_inc_n = 1'b1; key_dec_n = 1'b1;
    repeat (10) tick();
    chk("t5_both_keys", 32'(cnt_w), 32'(exp_v));
    key_inc_n = 1'b0;
    repeat (7) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t5_clear_wins", 32'(cnt_w), 32'h00);
    chk("t5_clear_no_boundary", 32'(bnd_w), 32'h0);
    repeat (5) tick();
    key_inc_n = 1'b1;
    repeat (10) tick();
    chk("t5_after_clear", 32'(cnt_w), 32'h00);

    // 6: reset while repeating, then re-press
    key_inc_n = 1'b0;
    repeat (44) tick();
    exp_v = AR ? 5 : 1;
    chk("t6_before_reset", 32'(cnt_w), 32'(exp_v));
    reset_n = 1'b0; key_inc_n = 1'b1;
    tick();
    reset_n = 1'b1;
    chk("t6_reset", 32'(cnt_w), 32'h00);
    repeat (30) tick();
    chk("t6_no_step", 32'(cnt_w), 32'h00);
    key_inc_n = 1'b0;
    repeat (10) tick();
    key_inc_n = 1'b1;
    repeat (10) tick();
    chk("t6_repress", 32'(cnt_w), 32'h01);

    // key held across reset release counts as a new press
    key_inc_n = 1'b0; reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    repeat (7) tick();
    chk("held_reset_before", 32'(cnt_w), 32'h00);
    tick();
    chk("held_reset_step", 32'(cnt_w), 32'h01);
    key_inc_n = 1'b1;
    repeat (10) tick();

    // random phase: fast toggling, then long holds
    for (int i = 0; i < 700; i++) begin
      p = (i < 300) ? 7 : 45;
      if ($urandom_range(p) == 0) key_inc_n = ~key_inc_n;
      if ($urandom_range(p) == 0) key_dec_n = ~key_dec_n;
      clear   = ($urandom_range(39) == 0);
      reset_n = ($urandom_range(249) != 0);
      tick();
    end
    reset_n = 1'b1; clear = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
